// File: rtl/serial_tx.sv
// serial_tx: 8N1 UART transmitter that pulls bytes from a ready/read upstream
module serial_tx #(
  parameter int N = 8,
  parameter int BAUD_DIV = 417
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_rdy,
  input  logic [N-1:0] i_data,
  output logic         o_rd,
  output logic         o_tx,
  output logic         o_busy
);
  localparam int CW = $clog2(BAUD_DIV);
  localparam int BW = $clog2(N + 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [BW-1:0] r_bit;
  logic [N-1:0] r_shift;
  logic w_tc, w_last;
  assign w_tc = r_cnt == CW'(BAUD_DIV - 1);
  assign w_last = r_bit == BW'(N - 1);
  assign o_rd = i_rst_n && (r_state == IDLE) && i_rdy;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = o_rd ? START : IDLE;
      START:   w_next = w_tc ? DATA : START;
      DATA:    w_next = (w_tc && w_last) ? STOP : DATA;
      STOP:    w_next = w_tc ? IDLE : STOP;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_bit   <= '0;
      r_shift <= '1;
      o_tx    <= 1'b1;
      o_busy  <= 1'b0;
    end else begin
      r_state <= w_next;
      o_tx    <= r_state == START ? 1'b0 : r_state == DATA ? r_shift[0] : 1'b1;
      o_busy  <= r_state != IDLE;
      r_cnt   <= (r_state == IDLE || w_tc) ? '0 : r_cnt + 1'b1;
      if (o_rd)
        r_shift <= i_data;
      else if (r_state == DATA && w_tc)
        r_shift <= {1'b1, r_shift[N-1:1]};
      if (r_state == START && w_tc)
        r_bit <= '0;
      else if (r_state == DATA && w_tc)
        r_bit <= r_bit + 1'b1;
    end
  end
endmodule

// File: tb/tb_serial_tx.sv
// tb_serial_tx: directed self-checking bench for serial_tx with BAUD_DIV=4
module tb_serial_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic rdy = 1'b0;
  logic [7:0] data = 8'h00;
  logic pipe = 1'b0;
  logic wr = 1'b0;
  logic [7:0] wdata = 8'h00;
  logic up_rdy = 1'b0;
  logic [7:0] up_data = 8'h00;
  logic w_rdy, o_rd, o_tx, o_busy;
  logic [7:0] w_data;
  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_start = 0;
  int first_start = 0;
  assign w_rdy = pipe ? up_rdy : rdy;
  assign w_data = pipe ? up_data : data;
  serial_tx #(.N(8), .BAUD_DIV(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_rdy(w_rdy), .i_data(w_data),
    .o_rd(o_rd), .o_tx(o_tx), .o_busy(o_busy)
  );
  always #5 clk = ~clk;
  function automatic logic [7:0] swap_case(input logic [7:0] c);
    return ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A)) ? c ^ 8'h20 : c;
  endfunction
  always @(posedge clk) begin
    if (wr) begin
      up_data <= swap_case(wdata);
      up_rdy  <= 1'b1;
    end else if (o_rd && pipe) begin
      up_rdy <= 1'b0;
    end
  end
  task automatic tick;
    @(posedge clk);
    #1;
    cyc++;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
    end
  endtask
  task automatic frame(input logic [7:0] b, input int rd_exp);
    int busy_n = 0;
    int rd_n = 0;
    logic e;
    for (int i = 0; i < 40; i++) begin
      tick;
      e = i < 4 ? 1'b0 : i >= 36 ? 1'b1 : b[(i - 4) / 4];
      chk("tx_bit", o_tx, e);
      if (i == 0) last_start = cyc;
      busy_n += o_busy;
      rd_n += o_rd;
    end
    chk("busy_len", busy_n, 40);
    chk("rd_in_frame", rd_n, rd_exp);
  endtask
  initial begin
    rdy = 1'b1;
    data = 8'h55;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("rst_tx", o_tx, 1);
      chk("rst_busy", o_busy, 0);
      chk("rst_rd", o_rd, 0);
    end
    rdy = 1'b0;
    rst_n = 1'b1;
    tick;
    tick;
    chk("idle_tx", o_tx, 1);
    chk("idle_busy", o_busy, 0);
    rdy = 1'b1;
    #1;
    chk("single_rd", o_rd, 1);
    tick;
    rdy = 1'b0;
    data = 8'hFF;
    chk("single_rd_drop", o_rd, 0);
    chk("single_tx_lag", o_tx, 1);
    frame(8'h55, 0);
    tick;
    chk("single_end_tx", o_tx, 1);
    chk("single_end_busy", o_busy, 0);
    data = 8'h00;
    rdy = 1'b1;
    #1;
    chk("b2b_rd1", o_rd, 1);
    tick;
    data = 8'hFF;
    frame(8'h00, 1);
    first_start = last_start;
    tick;
    rdy = 1'b0;
    chk("b2b_rd2_drop", o_rd, 0);
    frame(8'hFF, 0);
    chk("b2b_gap", last_start - first_start, 41);
    data = 8'h3C;
    rdy = 1'b1;
    #1;
    chk("held_rd1", o_rd, 1);
    tick;
    chk("held_rd1_once", o_rd, 0);
    fork
      frame(8'h3C, 1);
      begin #95; data = 8'hA5; end
    join
    first_start = last_start;
    tick;
    chk("held_rd2_once", o_rd, 0);
    fork
      frame(8'hA5, 1);
      begin #95; data = 8'h0F; end
    join
    chk("held_period", last_start - first_start, 41);
    tick;
    chk("held_rd3_once", o_rd, 0);
    frame(8'h0F, 1);
    rdy = 1'b0;
    tick;
    chk("held_end_busy", o_busy, 0);
    data = 8'h00;
    rdy = 1'b1;
    #1;
    chk("abort_rd", o_rd, 1);
    tick;
    rdy = 1'b0;
    repeat (18) tick;
    chk("abort_mid_tx", o_tx, 0);
    chk("abort_mid_busy", o_busy, 1);
    rst_n = 1'b0;
    rdy = 1'b1;
    #1;
    chk("abort_rd_rst", o_rd, 0);
    tick;
    chk("abort_tx", o_tx, 1);
    chk("abort_busy", o_busy, 0);
    rst_n = 1'b1;
    data = 8'h96;
    #1;
    chk("release_rd", o_rd, 1);
    tick;
    rdy = 1'b0;
    frame(8'h96, 0);
    tick;
    pipe = 1'b1;
    wdata = 8'h61;
    wr = 1'b1;
    tick;
    wr = 1'b0;
    chk("pipe_rd", o_rd, 1);
    tick;
    chk("pipe_bsy_clear", up_rdy, 0);
    chk("pipe_rd_drop", o_rd, 0);
    frame(8'h41, 0);
    tick;
    chk("pipe_end_busy", o_busy, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/serial_tx.md
# serial_tx

Serial transmitter that reads bytes from an upstream ready/read port and shifts each one out on a UART line as an 8N1 frame. It is the reading end of the `o_rdy`/`o_data`/`i_rd` interface presented by pipeline stages in the UART design, such as the case-swap transform. It sits between the last stage of that pipeline and the Fomu TX pin.

## Interface
- `N`, 8: data bits per frame.
- `BAUD_DIV`, 417: clock cycles per bit; 48 MHz / 115200. Must be ≥ 2.

- `i_clk`  in  1  system clock; all logic is on the rising edge.
- `i_rst_n`  in  1  reset: synchronous and active-low.
- `i_rdy`  in  1  upstream result-ready condition.
- `i_data`  in  N  upstream read data.
- `o_rd`  out  1  read request to upstream.
- `o_tx`  out  1  serial line; idle high.
- `o_busy`  out  1  frame in progress.

## Operation
- States:
  - IDLE
  - START
  - DATA
  - STOP
- Transfer: a transfer happens on any edge where `o_rd && i_rdy`.
  - `o_rd` is combinational: `o_rd = i_rst_n && (state==IDLE) && i_rdy`.
  - `o_rd` is never high outside IDLE, so the upstream is never read while a frame is in flight.
- On a transfer edge:
  - `i_data` is captured into the shift register.
  - The baud counter is cleared.
  - State goes IDLE→START.
- `o_tx` is registered, and is a function of state:
  - IDLE = 1
  - START = 0
  - DATA = shift[0], LSB first
  - STOP = 1
- Baud counter: width `$clog2(BAUD_DIV)`. It counts 0..BAUD_DIV-1 in every non-IDLE state. At the terminal count:
  - START→DATA; bit index := 0.
  - DATA: shift right and increment bit index. After bit N-1, go to STOP.
  - STOP→IDLE.
- Bit index: width `$clog2(N+1)`. No wrap: it is reloaded on START→DATA.
- `o_busy` = (state != IDLE), registered.
- Upstream data changes while `o_rdy` is low, or during a frame: ignored. Only the captured copy is sent.
- Reset:
  - Values on the first edge with `i_rst_n` low: state=IDLE, `o_tx`=1, `o_busy`=0, counters=0, shift register=all ones.
  - `o_rd`=0 combinationally while `i_rst_n` is low.
  - Reset mid-frame aborts the frame: the line returns high on that edge and the partial byte is discarded. It is not re-sent.

## Timing
- Let edge T be the transfer edge.
  - `o_tx` falls after edge T+1: registered output of START.
  - START occupies BAUD_DIV cycles. Each data bit occupies BAUD_DIV cycles. STOP occupies BAUD_DIV cycles.
  - Frame length is (N+2)·BAUD_DIV cycles of line time.
- Back-to-back frames:
  - IDLE is entered for at least 1 cycle between frames.
  - The effective stop bit is therefore BAUD_DIV+1 cycles.
  - Minimum frame-to-frame period is (N+2)·BAUD_DIV+1 cycles.
- Upstream that clears `o_rdy` on the read edge (as pipeline stages do) sees exactly one read per frame.
- `i_rdy` held high continuously produces one read per IDLE entry, never two.
- Deassertion of `i_rst_n` with `i_rdy` already high: a transfer is possible on the first edge after release.

## Test plan
- **Reset.** Hold `i_rst_n`=0 for 3 cycles with `i_rdy`=1 -> `o_tx`=1, `o_busy`=0, `o_rd`=0 throughout; no frame starts.
- **Single byte.** BAUD_DIV=4, present 0x55 with `i_rdy`=1 for one transfer -> `o_rd` high exactly 1 cycle, then `o_tx` = 0,1,0,1,0,1,0,1,0,1.
  - Each value is held 4 cycles: start, 8 data LSB first, stop. That is 40 cycles.
  - `o_busy` is high for 40 cycles.
- **Back-to-back.** BAUD_DIV=4, bytes 0x00 then 0xFF, with `i_rdy` re-asserted immediately -> frame 2 start bit begins 41 cycles after frame 1 start. Exactly 2 `o_rd` pulses are seen.
- **Held ready.** Hold `i_rdy`=1 for 100 cycles and never clear it, BAUD_DIV=4 -> `o_rd` pulses only at cycles where state is IDLE, i.e. one per 41 cycles.
  - `i_data` changes mid-frame do not alter the bits on the line.
- **Reset mid-frame.** Assert `i_rst_n`=0 during DATA bit 3 of 0x00 -> `o_tx`=1 on the next edge and `o_busy`=0. After release, the next frame carries the new byte, not the remainder of 0x00.
- **Pipeline integration.** Write 'a' (0x61) into the case-swap stage, connecting its `o_rdy`/`o_data`/`i_rd` to this block -> the line carries 0x41 ('A'): bits 1,0,0,0,0,0,1,0 after start.
  - The stage's `o_bsy` clears on the read edge.
